// File: rtl/explosion_pkg.sv
// Shared playfield geometry, blast colours, FSM encoding and clipping helpers for the explosion block.
// Values match those used by the bomb, bomberman and display blocks.
package explosion_pkg;

    localparam int BM_TILE  = 32;
    localparam int BM_PF_X0 = 144;
    localparam int BM_PF_Y0 = 35;
    localparam int BM_PF_X1 = 784;
    localparam int BM_PF_Y1 = 515;

    localparam logic [11:0] BM_BLAST_COLOR   = 12'hF80;
    localparam logic [11:0] BM_FLICKER_COLOR = 12'hFF0;
    localparam int          FLICKER_BIT      = 22;

    typedef logic [10:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_CLEAR
    } state_t;

    // max(c - off, lim) without ever going below zero
    function automatic coord_t clip_lo(input coord_t c, input coord_t off, input coord_t lim);
        return (c < lim + off) ? lim : c - off;
    endfunction

    function automatic coord_t clip_hi(input coord_t c, input coord_t off, input coord_t lim);
        return (c + off > lim) ? lim : c + off;
    endfunction

endpackage

// File: rtl/explosion_rect_hit.sv
// Combinational test: does a SIZE x SIZE box at (px,py) intersect the half-open rectangle [x0,x1) x [y0,y1)?
// Latency: none (pure combinational). Backpressure: none.
// SIZE=1 degenerates to a point-in-rectangle test.
module explosion_rect_hit #(
    parameter int SIZE = 1
) (
    input  logic [10:0] px,
    input  logic [10:0] py,
    input  logic [10:0] x0,
    input  logic [10:0] x1,
    input  logic [10:0] y0,
    input  logic [10:0] y1,
    output logic        hit
);

    localparam logic [10:0] SZ = 11'(SIZE);

    assign hit = (px < x1) && (px + SZ > x0) && (py < y1) && (py + SZ > y0);

endmodule

// File: rtl/explosion.sv
// Plus-shaped bomb blast: latches centre on detonate, holds it DURATION cycles, drives pixel enable/colour and a one-shot player hit.
// Latency: explosion_on/rgb_out/player_hit one clk after inputs; active the cycle after detonate. Backpressure: none, detonate while busy is dropped.
// Optional EXPLOSION_FLICKER_EN: rgb_out alternates with a yellow tint on counter bit FLICKER_BIT.
module explosion
    import explosion_pkg::*;
#(
    parameter int          TILE     = BM_TILE,
    parameter int          RANGE    = 2,
    parameter int          DURATION = 50_000_000,
    parameter int          PF_X0    = BM_PF_X0,
    parameter int          PF_Y0    = BM_PF_Y0,
    parameter int          PF_X1    = BM_PF_X1,
    parameter int          PF_Y1    = BM_PF_Y1,
    parameter logic [11:0] COLOR    = BM_BLAST_COLOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        detonate,
    input  logic [9:0]  exploding_bomb_x,
    input  logic [9:0]  exploding_bomb_y,
    input  logic [9:0]  b_x,
    input  logic [9:0]  b_y,
    input  logic [9:0]  v_x,
    input  logic [9:0]  v_y,
    output logic [9:0]  explosion_x,
    output logic [9:0]  explosion_y,
    output logic        explosion_active,
    output logic        explosion_on,
    output logic [11:0] rgb_out,
    output logic        player_hit
);

    localparam int          CW     = (DURATION > 1) ? $clog2(DURATION) : 1;
    localparam logic [CW-1:0] LAST = CW'(DURATION - 1);
    localparam coord_t      ARM_LO = coord_t'(RANGE * TILE);
    localparam coord_t      ARM_HI = coord_t'((RANGE + 1) * TILE);
    localparam coord_t      TILE_W = coord_t'(TILE);

    state_t        state, state_nxt;
    logic          latch;
    logic [CW-1:0] counter;
    logic          hit_done;
    coord_t        left, right, top, bottom;
    coord_t        cx, cy, bx, by, vx, vy;
    logic          pix_h, pix_v, bm_h, bm_v;
    logic          active, pix_raw, bm_raw;
    logic [11:0]   blast_color;

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (detonate) begin
                    state_nxt = ST_ACTIVE;
                    latch     = 1'b1;
                end
            end
            ST_ACTIVE: if (counter == LAST) state_nxt = ST_CLEAR;
            ST_CLEAR:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            counter <= '0;
        end else begin
            state <= state_nxt;
            if (latch)
                counter <= '0;
            else if (state == ST_ACTIVE)
                counter <= counter + CW'(1);
        end
    end

    // Bounds are fixed for the whole blast, so clip once at latch time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            explosion_x <= '0;
            explosion_y <= '0;
            left        <= '0;
            right       <= '0;
            top         <= '0;
            bottom      <= '0;
        end else if (latch) begin
            explosion_x <= exploding_bomb_x;
            explosion_y <= exploding_bomb_y;
            left        <= clip_lo({1'b0, exploding_bomb_x}, ARM_LO, coord_t'(PF_X0));
            right       <= clip_hi({1'b0, exploding_bomb_x}, ARM_HI, coord_t'(PF_X1));
            top         <= clip_lo({1'b0, exploding_bomb_y}, ARM_LO, coord_t'(PF_Y0));
            bottom      <= clip_hi({1'b0, exploding_bomb_y}, ARM_HI, coord_t'(PF_Y1));
        end
    end

    assign cx = {1'b0, explosion_x};
    assign cy = {1'b0, explosion_y};
    assign bx = {1'b0, b_x};
    assign by = {1'b0, b_y};
    assign vx = {1'b0, v_x};
    assign vy = {1'b0, v_y};

    explosion_rect_hit #(.SIZE(1)) u_pix_h (
        .px(vx), .py(vy), .x0(left), .x1(right), .y0(cy), .y1(cy + TILE_W), .hit(pix_h)
    );
    explosion_rect_hit #(.SIZE(1)) u_pix_v (
        .px(vx), .py(vy), .x0(cx), .x1(cx + TILE_W), .y0(top), .y1(bottom), .hit(pix_v)
    );
    explosion_rect_hit #(.SIZE(TILE)) u_bm_h (
        .px(bx), .py(by), .x0(left), .x1(right), .y0(cy), .y1(cy + TILE_W), .hit(bm_h)
    );
    explosion_rect_hit #(.SIZE(TILE)) u_bm_v (
        .px(bx), .py(by), .x0(cx), .x1(cx + TILE_W), .y0(top), .y1(bottom), .hit(bm_v)
    );

    assign active           = (state == ST_ACTIVE);
    assign explosion_active = active;
    assign pix_raw          = (pix_h | pix_v) & active;
    assign bm_raw           = (bm_h | bm_v) & active;

`ifdef EXPLOSION_FLICKER_EN
    // Short blasts never reach the flicker bit, so they stay on the base colour.
    localparam bit FLICKER_OK = (CW > FLICKER_BIT);
    localparam int FB         = FLICKER_OK ? FLICKER_BIT : CW - 1;
    assign blast_color = (FLICKER_OK && counter[FB]) ? BM_FLICKER_COLOR : COLOR;
`else
    assign blast_color = COLOR;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            explosion_on <= 1'b0;
            rgb_out      <= '0;
            player_hit   <= 1'b0;
            hit_done     <= 1'b0;
        end else begin
            explosion_on <= pix_raw;
            rgb_out      <= pix_raw ? blast_color : 12'h000;
            player_hit   <= bm_raw & ~hit_done;
            if (latch)
                hit_done <= 1'b0;
            else if (bm_raw)
                hit_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_explosion.sv
// Randomized bench for explosion: a time-window reference model predicts each cycle's outputs into a scoreboard queue,
// and a negedge monitor pops and compares them against the DUT.
module tb_explosion;

    localparam int          T     = 32;
    localparam int          R     = 2;
    localparam int          D     = 100;
    localparam int          PX0   = 144;
    localparam int          PY0   = 35;
    localparam int          PX1   = 784;
    localparam int          PY1   = 515;
    localparam logic [11:0] COLOR = 12'hF80;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        detonate = 1'b0;
    logic [9:0]  exploding_bomb_x = '0, exploding_bomb_y = '0;
    logic [9:0]  b_x = '0, b_y = '0, v_x = '0, v_y = '0;
    logic [9:0]  explosion_x, explosion_y;
    logic        explosion_active, explosion_on, player_hit;
    logic [11:0] rgb_out;

    always #5 clk = ~clk;

    explosion #(.DURATION(D)) dut (
        .clk(clk), .reset(reset), .detonate(detonate),
        .exploding_bomb_x(exploding_bomb_x), .exploding_bomb_y(exploding_bomb_y),
        .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
        .explosion_x(explosion_x), .explosion_y(explosion_y),
        .explosion_active(explosion_active), .explosion_on(explosion_on),
        .rgb_out(rgb_out), .player_hit(player_hit)
    );

    typedef struct packed {
        logic        act;
        logic        on;
        logic [11:0] rgb;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hit;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: blast is live on edges a_start .. a_start+D-1, CLEAR on a_start+D.
    int n       = 0;
    int a_start = -1000000;
    int mcx     = 0;
    int mcy     = 0;
    bit mhit_done = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction
    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int clamp10(input int v); return (v < 0) ? 0 : ((v > 1023) ? 1023 : v); endfunction

    function automatic bit box_hit(input int x, input int y, input int sz);
        int l, r, t, b;
        bit h, v;
        l = imax(mcx - R * T, PX0);
        r = imin(mcx + (R + 1) * T, PX1);
        t = imax(mcy - R * T, PY0);
        b = imin(mcy + (R + 1) * T, PY1);
        h = (x < r) && (x + sz > l) && (y < mcy + T) && (y + sz > mcy);
        v = (x < mcx + T) && (x + sz > mcx) && (y < b) && (y + sz > t);
        return h || v;
    endfunction

    function automatic logic [11:0] color_at(input int cnt);
`ifdef EXPLOSION_FLICKER_EN
        return ((cnt >> 22) & 1) != 0 ? 12'hFF0 : COLOR;
`else
        return (cnt >= 0) ? COLOR : COLOR;
`endif
    endfunction

    task automatic step(input bit rst_v, input bit det, input int ex, input int ey,
                        input int bx, input int by, input int vx, input int vy);
        exp_t e;
        int   nn;
        bit   prev_act;
        reset            = rst_v;
        detonate         = det;
        exploding_bomb_x = 10'(ex);
        exploding_bomb_y = 10'(ey);
        b_x = 10'(bx);
        b_y = 10'(by);
        v_x = 10'(vx);
        v_y = 10'(vy);
        nn = n + 1;
        e  = '0;
        if (!rst_v) begin
            a_start   = -1000000;
            mcx       = 0;
            mcy       = 0;
            mhit_done = 1'b0;
        end else begin
            prev_act = (nn - 1 >= a_start) && (nn - 1 <= a_start + D - 1);
            e.on     = prev_act && box_hit(vx, vy, 1);
            e.rgb    = e.on ? color_at(nn - 1 - a_start) : 12'h000;
            e.hit    = prev_act && box_hit(bx, by, T) && !mhit_done;
            if (e.hit) mhit_done = 1'b1;
            if (det && !((nn - 1 >= a_start) && (nn - 1 <= a_start + D))) begin
                a_start   = nn;
                mcx       = ex;
                mcy       = ey;
                mhit_done = 1'b0;
            end
            e.act = (nn >= a_start) && (nn <= a_start + D - 1);
            e.x   = 10'(mcx);
            e.y   = 10'(mcy);
        end
        @(posedge clk);
        n = nn;
        sb.push_back(e);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("explosion_active", int'(explosion_active), int'(e.act));
                check("explosion_on", int'(explosion_on), int'(e.on));
                check("rgb_out", int'(rgb_out), int'(e.rgb));
                check("explosion_x", int'(explosion_x), int'(e.x));
                check("explosion_y", int'(explosion_y), int'(e.y));
                check("player_hit", int'(player_hit), int'(e.hit));
            end
        end
    end

    int pvx[4] = '{210, 368, 280, 210};
    int pvy[4] = '{170, 170, 100, 100};

    initial begin
        int bx, by, vx, vy, cx, cy;
        bit det;
        #1;
        for (int i = 0; i < 5; i++) step(1'b0, i[0], 272, 163, 0, 0, 0, 0);

        // First blast at (272,163); retrigger at cycle 50 ignored, re-arm right after CLEAR.
        step(1'b1, 1'b1, 272, 163, 600, 450, 0, 0);
        for (int i = 0; i < 105; i++) begin
            if (i < 4) begin
                vx = pvx[i];
                vy = pvy[i];
            end else begin
                vx = $urandom_range(400, 180);
                vy = $urandom_range(290, 70);
            end
            if ((i >= 10 && i < 15) || (i >= 20 && i < 25)) begin
                bx = 336; by = 163;
            end else if (i < 25) begin
                bx = 600; by = 450;
            end else begin
                bx = $urandom_range(420, 150);
                by = $urandom_range(300, 60);
            end
            det = (i == 49) || (i >= 98 && i <= 101);
            if (i == 49) step(1'b1, det, 400, 300, bx, by, vx, vy);
            else         step(1'b1, det, 144, 35, bx, by, vx, vy);
        end

        // Blast clipped at the playfield corner, then async reset mid-blast.
        for (int i = 0; i < 28; i++) begin
            if (i == 0) begin vx = 143; vy = 40; end
            else begin vx = $urandom_range(300, 100); vy = $urandom_range(200, 0); end
            step(1'b1, 1'b0, 0, 0, $urandom_range(250, 100), $urandom_range(150, 0), vx, vy);
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async_active", int'(explosion_active), 0);
        check("async_on", int'(explosion_on), 0);
        check("async_rgb", int'(rgb_out), 0);
        check("async_x", int'(explosion_x), 0);
        check("async_y", int'(explosion_y), 0);
        check("async_hit", int'(player_hit), 0);
        a_start = -1000000; mcx = 0; mcy = 0; mhit_done = 1'b0;
        @(posedge clk);
        n = n + 1;
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 304, 195, 0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);

        // Random blasts anywhere on the playfield.
        for (int k = 0; k < 3; k++) begin
            cx = PX0 + T * $urandom_range(19, 0);
            cy = PY0 + T * $urandom_range(14, 0);
            step(1'b1, 1'b1, cx, cy, 0, 0, 0, 0);
            for (int i = 0; i < 115; i++) begin
                det = ($urandom_range(39, 0) == 0);
                step(1'b1, det,
                     PX0 + T * $urandom_range(19, 0), PY0 + T * $urandom_range(14, 0),
                     clamp10(cx - 110 + $urandom_range(220, 0)), clamp10(cy - 110 + $urandom_range(220, 0)),
                     clamp10(cx - 120 + $urandom_range(240, 0)), clamp10(cy - 120 + $urandom_range(240, 0)));
            end
        end

        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
